// File: rtl/issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_pkg
// Brief    : shared core constants, opcode codes and issue-queue state encoding
// Revision : 1.0
// ============================================================================
package issue_queue_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_WAIT_BR = 1'b1
  } iq_state_e;

  localparam int          c_num_regs    = 32;
  localparam logic [11:0] c_code_load   = 12'h003;
  localparam logic [11:0] c_code_opimm  = 12'h013;
  localparam logic [11:0] c_code_op     = 12'h033;
  localparam logic [11:0] c_code_branch = 12'h063;

endpackage
`default_nettype wire

// File: rtl/iq_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : iq_scoreboard
// Brief    : 32-entry pending-load busy vector with set/clear and rs lookup
// Revision : 1.0
// ============================================================================
module iq_scoreboard
  import issue_queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [4:0]            set_idx,
  input  logic                  clr_en,
  input  logic [4:0]            clr_idx,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [c_num_regs-1:0] busy
);

  logic [c_num_regs-1:0] r_busy;
  logic [c_num_regs-1:0] w_busy_next;

  // Set is applied after clear so a same-cycle set of the same index wins.
  always_comb begin
    w_busy_next = r_busy;
    if (clr_en) w_busy_next[clr_idx] = 1'b0;
    if (set_en) w_busy_next[set_idx] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  assign busy  = r_busy;
  assign busy1 = (rs1 != 5'd0) && r_busy[rs1];
  assign busy2 = (rs2 != 5'd0) && r_busy[rs2];

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Brief    : in-order issue queue with load-use hazard stall and branch hold
// Revision : 1.0
// ============================================================================
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [11:0]     in_code,
  input  logic            in_isLoad,
  input  logic            in_isBranch,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_code,
  output logic            out_isLoad,
  output logic            out_isBranch,
  output logic [31:0]     out_pc,
  input  logic            ld_done,
  input  logic [4:0]      ld_rd,
  input  logic            br_resolve,
  input  logic            br_taken,
  output logic [31:0]     busy
);

  localparam int             c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_ptr_one = 1;

  logic [4:0]      r_rd_mem   [DEPTH];
  logic [4:0]      r_rs1_mem  [DEPTH];
  logic [4:0]      r_rs2_mem  [DEPTH];
  logic [XLEN-1:0] r_imm_mem  [DEPTH];
  logic [11:0]     r_code_mem [DEPTH];
  logic            r_ld_mem   [DEPTH];
  logic            r_br_mem   [DEPTH];
  logic [31:0]     r_pc_mem   [DEPTH];

  logic [c_aw:0]   r_wptr;
  logic [c_aw:0]   r_rptr;
  iq_state_e       r_state;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_haz1;
  logic            w_haz2;
  logic [c_aw-1:0] w_head;

  assign w_full   = (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]) && (r_wptr[c_aw] != r_rptr[c_aw]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_head   = r_rptr[c_aw-1:0];
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_flush  = (r_state == ST_WAIT_BR) && br_resolve && br_taken;

  // Head fields read as zero while empty, so an empty queue never looks hazardous.
  assign out_rd       = w_empty ? '0   : r_rd_mem[w_head];
  assign out_rs1      = w_empty ? '0   : r_rs1_mem[w_head];
  assign out_rs2      = w_empty ? '0   : r_rs2_mem[w_head];
  assign out_imm      = w_empty ? '0   : r_imm_mem[w_head];
  assign out_code     = w_empty ? '0   : r_code_mem[w_head];
  assign out_isLoad   = w_empty ? 1'b0 : r_ld_mem[w_head];
  assign out_isBranch = w_empty ? 1'b0 : r_br_mem[w_head];
  assign out_pc       = w_empty ? '0   : r_pc_mem[w_head];

  assign out_valid = !w_empty && !w_haz1 && !w_haz2 && (r_state == ST_RUN);

  iq_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (w_pop && out_isLoad),
    .set_idx (out_rd),
    .clr_en  (ld_done),
    .clr_idx (ld_rd),
    .rs1     (out_rs1),
    .rs2     (out_rs2),
    .busy1   (w_haz1),
    .busy2   (w_haz2),
    .busy    (busy)
  );

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_rd_mem[r_wptr[c_aw-1:0]]   <= in_rd;
      r_rs1_mem[r_wptr[c_aw-1:0]]  <= in_rs1;
      r_rs2_mem[r_wptr[c_aw-1:0]]  <= in_rs2;
      r_imm_mem[r_wptr[c_aw-1:0]]  <= in_imm;
      r_code_mem[r_wptr[c_aw-1:0]] <= in_code;
      r_ld_mem[r_wptr[c_aw-1:0]]   <= in_isLoad;
      r_br_mem[r_wptr[c_aw-1:0]]   <= in_isBranch;
      r_pc_mem[r_wptr[c_aw-1:0]]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_state <= ST_RUN;
    end else begin
      // A taken branch discards everything queued behind it, including this cycle's push.
      if (w_flush) begin
        r_rptr <= r_wptr;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_ptr_one;
        if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      end
      case (r_state)
        ST_RUN:     if (w_pop && out_isBranch) r_state <= ST_WAIT_BR;
        ST_WAIT_BR: if (br_resolve)            r_state <= ST_RUN;
        default:                               r_state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_queue
// Brief    : directed vector table, corner sequences and model-checked random run
// Revision : 1.0
// ============================================================================
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid, in_ready;
  logic [4:0]      in_rd, in_rs1, in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [11:0]     in_code;
  logic            in_isLoad, in_isBranch;
  logic [31:0]     in_pc;
  logic            out_valid, out_ready;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [11:0]     out_code;
  logic            out_isLoad, out_isBranch;
  logic [31:0]     out_pc;
  logic            ld_done;
  logic [4:0]      ld_rd;
  logic            br_resolve, br_taken;
  logic [31:0]     busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_code(in_code), .in_isLoad(in_isLoad), .in_isBranch(in_isBranch), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_code(out_code), .out_isLoad(out_isLoad), .out_isBranch(out_isBranch), .out_pc(out_pc),
    .ld_done(ld_done), .ld_rd(ld_rd),
    .br_resolve(br_resolve), .br_taken(br_taken),
    .busy(busy)
  );

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [11:0] code;
    logic        isLoad, isBranch;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [4:0]  rd, rs1;
    logic        ld, ordy, ldd;
    logic [4:0]  ldrd;
    logic        e_ir, e_ov;
    logic [4:0]  e_rd;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mkv(input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic ld, input logic ordy, input logic ldd,
                               input logic [4:0] ldrd, input logic e_ir, input logic e_ov,
                               input logic [4:0] e_rd, input logic [31:0] e_busy);
    vec_t v;
    v.iv = iv; v.rd = rd; v.rs1 = rs1; v.ld = ld; v.ordy = ordy; v.ldd = ldd;
    v.ldrd = ldrd; v.e_ir = e_ir; v.e_ov = e_ov; v.e_rd = e_rd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_code = 0;
    in_isLoad = 0; in_isBranch = 0; in_pc = 0; out_ready = 0;
    ld_done = 0; ld_rd = 0; br_resolve = 0; br_taken = 0;
  endtask

  task automatic put(input logic [4:0] rd, input logic [4:0] rs1, input logic ld, input logic br);
    in_valid = 1; in_rd = rd; in_rs1 = rs1; in_rs2 = 0;
    in_imm = 32'h1000 + 32'(rd); in_pc = 32'h8000 + 32'(rd) * 4;
    in_isLoad = ld; in_isBranch = br;
    in_code = ld ? c_code_load : (br ? c_code_branch : c_code_opimm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  // Reference model state
  ent_t        mq[$];
  logic [31:0] mbusy;
  logic        mwait;

  task automatic random_run(input int n);
    ent_t e, h;
    logic exp_ir, exp_ov, haz, push, pop, was_wait;
    mq.delete(); mbusy = 0; mwait = 0;
    for (int c = 0; c < n; c++) begin
      e.rd = 5'($urandom_range(0, 7)); e.rs1 = 5'($urandom_range(0, 7));
      e.rs2 = 5'($urandom_range(0, 7)); e.imm = $urandom; e.code = 12'($urandom);
      e.isLoad = ($urandom_range(0, 9) < 3); e.isBranch = !e.isLoad && ($urandom_range(0, 9) < 2);
      e.pc = $urandom;
      in_valid = ($urandom_range(0, 9) < 7);
      in_rd = e.rd; in_rs1 = e.rs1; in_rs2 = e.rs2; in_imm = e.imm; in_code = e.code;
      in_isLoad = e.isLoad; in_isBranch = e.isBranch; in_pc = e.pc;
      out_ready = ($urandom_range(0, 9) < 7);
      ld_done = ($urandom_range(0, 9) < 3); ld_rd = 5'($urandom_range(0, 7));
      br_resolve = ($urandom_range(0, 9) < 2); br_taken = $urandom_range(0, 1) == 1;
      #2;
      exp_ir = (mq.size() < DEPTH);
      haz = 0;
      if (mq.size() > 0) begin
        h = mq[0];
        haz = (h.rs1 != 0 && mbusy[h.rs1]) || (h.rs2 != 0 && mbusy[h.rs2]);
      end else begin
        h = '{default: '0};
      end
      exp_ov = (mq.size() > 0) && !haz && !mwait;
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_ir));
      chk("rnd_out_valid", 64'(out_valid), 64'(exp_ov));
      chk("rnd_busy", 64'(busy), 64'(mbusy));
      chk("rnd_head_regs", {out_rd, out_rs1, out_rs2, out_code, out_isLoad, out_isBranch},
          {h.rd, h.rs1, h.rs2, h.code, h.isLoad, h.isBranch});
      chk("rnd_head_imm_pc", {out_imm, out_pc}, {h.imm, h.pc});
      push = in_valid && exp_ir;
      pop = exp_ov && out_ready;
      was_wait = mwait;
      tick();
      if (ld_done) mbusy[ld_rd] = 1'b0;
      if (pop) begin
        h = mq.pop_front();
        if (h.isLoad && h.rd != 0) mbusy[h.rd] = 1'b1;
        if (h.isBranch) mwait = 1;
      end
      if (was_wait && br_resolve) begin
        mwait = 0;
        if (br_taken) mq.delete();
        else if (push) mq.push_back(e);
      end else if (push) begin
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    // Fill/refuse/drain, load-use stall, set-wins-over-clear.
    tbl[0]  = mkv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[1]  = mkv(1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0);
    tbl[2]  = mkv(1, 3, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0);
    tbl[3]  = mkv(1, 4, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0);
    tbl[4]  = mkv(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    tbl[5]  = mkv(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h0);
    tbl[6]  = mkv(0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 32'h0);
    tbl[7]  = mkv(0, 0, 0, 0, 1, 0, 0, 1, 1, 3, 32'h0);
    tbl[8]  = mkv(0, 0, 0, 0, 1, 0, 0, 1, 1, 4, 32'h0);
    tbl[9]  = mkv(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[10] = mkv(1, 5, 0, 1, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[11] = mkv(1, 6, 5, 0, 1, 0, 0, 1, 1, 5, 32'h0);
    tbl[12] = mkv(0, 0, 0, 0, 1, 0, 0, 1, 0, 6, 32'h20);
    tbl[13] = mkv(0, 0, 0, 0, 1, 0, 0, 1, 0, 6, 32'h20);
    tbl[14] = mkv(0, 0, 0, 0, 1, 1, 5, 1, 0, 6, 32'h20);
    tbl[15] = mkv(0, 0, 0, 0, 1, 0, 0, 1, 1, 6, 32'h0);
    tbl[16] = mkv(1, 7, 0, 1, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[17] = mkv(0, 0, 0, 0, 1, 1, 7, 1, 1, 7, 32'h0);
    tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80);
    tbl[19] = mkv(0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 32'h80);
    tbl[20] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1;
    tick();

    for (int i = 0; i < 21; i++) begin
      idle();
      if (tbl[i].iv) put(tbl[i].rd, tbl[i].rs1, tbl[i].ld, 1'b0);
      out_ready = tbl[i].ordy; ld_done = tbl[i].ldd; ld_rd = tbl[i].ldrd;
      #2;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_rd", i), 64'(out_rd), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      tick();
    end

    // br_resolve outside WAIT_BR has no effect.
    idle(); put(5'd1, 5'd0, 0, 0); tick();
    idle(); br_resolve = 1; br_taken = 1; #2;
    chk("run_resolve_ov_before", 64'(out_valid), 64'd1);
    tick(); idle(); #2;
    chk("run_resolve_ov_after", 64'(out_valid), 64'd1);
    out_ready = 1; tick();

    // Taken branch: three queued entries plus a same-cycle push are discarded.
    idle(); put(5'd0, 5'd0, 0, 1); tick();
    idle(); out_ready = 1; #2;
    chk("brT_branch_head", {out_valid, out_isBranch}, 2'b11);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); out_ready = 1; put(5'(9 + i), 5'd0, 0, 0); #2;
      chk("brT_hold_ov", 64'(out_valid), 64'd0);
      tick();
    end
    idle(); out_ready = 1; put(5'd12, 5'd0, 0, 0); br_resolve = 1; br_taken = 1; #2;
    chk("brT_resolve_in_ready", 64'(in_ready), 64'd1);
    chk("brT_resolve_ov", 64'(out_valid), 64'd0);
    tick(); idle(); #2;
    chk("brT_flushed_ov", 64'(out_valid), 64'd0);
    chk("brT_flushed_rd", 64'(out_rd), 64'd0);
    chk("brT_flushed_in_ready", 64'(in_ready), 64'd1);
    put(5'd14, 5'd0, 0, 0); tick(); idle(); #2;
    chk("brT_run_again", {out_valid, out_rd}, {1'b1, 5'd14});
    out_ready = 1; tick();

    // Not-taken branch with a full queue: entries survive and drain in order.
    idle(); put(5'd0, 5'd0, 0, 1); tick();
    idle(); out_ready = 1; tick();
    for (int i = 0; i < 4; i++) begin
      idle(); out_ready = 1; put(5'(16 + i), 5'd0, 0, 0); #2;
      chk("brN_hold_ov", 64'(out_valid), 64'd0);
      tick();
    end
    idle(); put(5'd20, 5'd0, 0, 0); br_resolve = 1; br_taken = 0; #2;
    chk("brN_full_in_ready", 64'(in_ready), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(); out_ready = 1; #2;
      chk($sformatf("brN_drain%0d", i), {out_valid, out_rd, out_pc},
          {1'b1, 5'(16 + i), 32'h8000 + 32'(16 + i) * 4});
      tick();
    end
    idle(); #2;
    chk("brN_empty_ov", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-drain with a load in flight.
    put(5'd3, 5'd0, 1, 0); tick();
    idle(); out_ready = 1; tick();
    idle(); put(5'd21, 5'd0, 0, 0); tick();
    put(5'd22, 5'd0, 0, 0); tick();
    idle(); out_ready = 1; #2;
    chk("rst_pre_busy", 64'(busy), 64'h8);
    chk("rst_pre_ov", 64'(out_valid), 64'd1);
    #1 reset = 0;
    #1;
    chk("rst_async_in_ready", 64'(in_ready), 64'd1);
    chk("rst_async_ov", 64'(out_valid), 64'd0);
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_rd", 64'(out_rd), 64'd0);
    idle(); tick();
    reset = 1;
    tick();

    random_run(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  fetch presents a decoded instruction.
REQ-006 SHALL have port in_ready  out  1  queue accepts this cycle.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-008 SHALL have port in_imm  in  XLEN  immediate; in_code  in  12  opcode/funct code.
REQ-009 SHALL have ports in_isLoad, in_isBranch  in  1 each; in_pc  in  32  instruction PC.
REQ-010 SHALL have port out_valid  out  1  head instruction issuable.
REQ-011 SHALL have port out_ready  in  1  execute consumes head.
REQ-012 SHALL have ports out_rd, out_rs1, out_rs2, out_imm, out_code, out_isLoad, out_isBranch, out_pc  out  widths as inputs  head entry fields.
REQ-013 SHALL have port ld_done  in  1  and ld_rd  in  5  load writeback completes for ld_rd.
REQ-014 SHALL have port br_resolve  in  1  and br_taken  in  1  outstanding branch resolved.
REQ-015 SHALL have port busy  out  32  load scoreboard vector (debug/forwarding).

Function
REQ-016 SHALL push when in_valid && in_ready; in_ready = !full (no push-through on full even if popping).
REQ-017 SHALL pop when out_valid && out_ready; push and pop in same cycle leave count unchanged.
REQ-018 SHALL present a pushed entry at the head no earlier than the next cycle (one-cycle minimum latency, no bypass).
REQ-019 SHALL drive out_* combinationally from the head entry; values undefined-but-stable-as-zero when empty.
REQ-020 SHALL use read/write pointers with one extra wrap bit; full = indices equal, wrap bits differ; empty = pointers equal.
REQ-021 SHALL declare hazard when head rs1!=0 and busy[rs1], or head rs2!=0 and busy[rs2].
REQ-022 SHALL assert out_valid = !empty && !hazard && state==RUN.
REQ-023 SHALL set busy[rd] on pop of a load with rd!=0; busy[0] always 0.
REQ-024 SHALL clear busy[ld_rd] on ld_done; set and clear of the same index in one cycle: set wins.
REQ-025 SHALL implement states RUN and WAIT_BR; RUN->WAIT_BR on pop of an isBranch entry.
REQ-026 SHALL in WAIT_BR hold out_valid=0, keep accepting pushes; WAIT_BR->RUN on br_resolve.
REQ-027 SHALL on br_resolve && br_taken flush: pointers equalised (empty), any same-cycle push dropped, in_ready still reflects pre-flush full.
REQ-028 SHALL on br_resolve && !br_taken retain all entries.
REQ-029 SHALL ignore br_resolve while in RUN.
REQ-030 SHALL leave busy unchanged by flush (issued loads remain in flight).

Reset
REQ-031 SHALL on reset low asynchronously: pointers 0, empty, state RUN, busy 0, out_valid 0, in_ready 1.
REQ-032 SHALL not require entry storage to be reset; out_* read zero-gated while empty.
REQ-033 SHALL, if reset asserts mid-operation, discard all entries and pending-load tracking.

Structure
REQ-034 SHALL take opcode code constants and the RUN/WAIT_BR state encoding from a shared core package.
REQ-035 SHALL instantiate one sub-module, iq_scoreboard (32-bit busy vector, set/clear/lookup).

Verification
REQ-036 SHALL cover: push 4 non-hazard entries with out_ready=0 -> in_ready=0 after 4th, 5th push refused, then drains in order.
REQ-037 SHALL cover: issue load rd=5, next head rs1=5 -> out_valid=0 until ld_done ld_rd=5, then out_valid=1 next comb evaluation.
REQ-038 SHALL cover: issue branch, 3 entries queued, br_resolve br_taken=1 -> queue empty next cycle, out_valid=0, state RUN.
REQ-039 SHALL cover: issue branch, br_resolve br_taken=0 -> queued entries issue unchanged in order.
REQ-040 SHALL cover: pop load rd=7 same cycle as ld_done ld_rd=7 -> busy[7]=1 afterwards.
REQ-041 SHALL cover: reset low mid-drain with 2 entries and busy[3]=1 -> immediately empty, busy=0, in_ready=1.
